// File: rtl/whr_op_sched_pkg.sv
// Shared definitions for the per-output-port wormhole scheduler:
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package whr_op_sched_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } sched_state_e;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int whr_clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/whr_op_sched_if.sv
// Request/grant and output-strobe bundle between the input controllers,
// one output-port scheduler and its crossbar column / output controller.
interface whr_op_sched_if #(
   parameter int NUM_PORTS = 5
);
   logic [NUM_PORTS-1:0] req_ip;
   logic [NUM_PORTS-1:0] req_head_ip;
   logic [NUM_PORTS-1:0] req_tail_ip;
   logic                 flow_ctrl_in;
   logic [NUM_PORTS-1:0] gnt_ip;
   logic [NUM_PORTS-1:0] xbr_ctrl_ip;
   logic                 flit_valid_out;
   logic                 flit_head_out;
   logic                 flit_tail_out;
   logic                 full;
   logic                 error;

   // Input-controller / downstream side
   modport master (
      output req_ip, req_head_ip, req_tail_ip, flow_ctrl_in,
      input  gnt_ip, xbr_ctrl_ip, flit_valid_out, flit_head_out,
             flit_tail_out, full, error
   );

   // Scheduler side
   modport slave (
      input  req_ip, req_head_ip, req_tail_ip, flow_ctrl_in,
      output gnt_ip, xbr_ctrl_ip, flit_valid_out, flit_head_out,
             flit_tail_out, full, error
   );
endinterface

// File: rtl/whr_op_sched_rr.sv
// Combinational round-robin arbiter: scans the request vector starting at
// the one-hot pointer position (wrapping around) and returns a one-hot
// grant for the first requester found. Pointer update lives in the parent.
module whr_op_sched_rr #(
   parameter int N = 5
) (
   input  logic [N-1:0] req_i,
   input  logic [N-1:0] ptr_i,
   output logic [N-1:0] gnt_o
);

   int   start_s;
   int   idx_s;
   logic found_s;

   // Locate pointer index, then pick first request at or after it
   always_comb begin
      gnt_o   = '0;
      start_s = 0;
      idx_s   = 0;
      found_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (ptr_i[i]) begin
            start_s = i;
         end else begin
            start_s = start_s;
         end
      end
      for (int off = 0; off < N; off++) begin
         idx_s = start_s + off;
         if (idx_s >= N) begin
            idx_s = idx_s - N;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req_i[idx_s]) begin
            gnt_o[idx_s] = 1'b1;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/whr_op_sched.sv
// Per-output-port packet scheduler. Arbitrates head flits round-robin,
// locks the winning input from head to tail, tracks downstream credits,
// and registers the crossbar select and flit strobes one cycle after
// the grant so they line up with the input buffer read data.
module whr_op_sched
   import whr_op_sched_pkg::*;
#(
   parameter int num_ports     = 5,
   parameter int buffer_size   = 8,
   parameter int credit_bypass = 1
) (
   input logic           clk,
   input logic           reset,
   whr_op_sched_if.slave bus
);

   localparam int CNT_W_RAW = whr_clog2(buffer_size + 1);
   localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(buffer_size);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Next round-robin start is the position just after the given one-hot
   function automatic logic [num_ports-1:0] rotl1(input logic [num_ports-1:0] v);
      return {v[num_ports-2:0], v[num_ports-1]};
   endfunction

   sched_state_e           state_q, state_d;
   logic [num_ports-1:0]   owner_q, owner_d;
   logic [num_ports-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]       credit_cnt_q, credit_cnt_d;
   logic                   error_q, error_d;
   logic [num_ports-1:0]   xbr_q;
   logic                   valid_q, head_q, tail_q, full_q;

   logic [num_ports-1:0]   eligible_s;
   logic [num_ports-1:0]   arb_gnt_s;
   logic [num_ports-1:0]   gnt_s;
   logic                   credit_avail_s;
   logic                   grant_any_s;
   logic                   err_proto_s;
   logic                   err_credit_s;

   assign eligible_s     = bus.req_ip & bus.req_head_ip;
   assign credit_avail_s = (credit_cnt_q != '0) ||
                           ((credit_bypass != 0) && bus.flow_ctrl_in);
   assign grant_any_s    = |gnt_s;

   whr_op_sched_rr #(.N(num_ports)) u_rr (
      .req_i (eligible_s),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt_s)
   );

   // FSM next state, grant selection and protocol error detection
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_s       = '0;
      err_proto_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            err_proto_s = |(bus.req_ip & ~bus.req_head_ip);
            gnt_s       = credit_avail_s ? arb_gnt_s : '0;
            if (|gnt_s) begin
               if (|(gnt_s & bus.req_tail_ip)) begin
                  rr_ptr_d = rotl1(gnt_s);
               end else begin
                  state_d = ST_LOCKED;
                  owner_d = gnt_s;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            err_proto_s = |(owner_q & bus.req_ip & bus.req_head_ip);
            gnt_s       = credit_avail_s ? (owner_q & bus.req_ip) : '0;
            if (|(gnt_s & bus.req_tail_ip)) begin
               state_d  = ST_IDLE;
               rr_ptr_d = rotl1(owner_q);
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_IDLE;
            owner_d = '0;
         end
      endcase
   end

   // Credit counter: grant consumes, return replenishes, both cancel out
   always_comb begin
      credit_cnt_d = credit_cnt_q;
      err_credit_s = 1'b0;
      if (grant_any_s && !bus.flow_ctrl_in) begin
         credit_cnt_d = credit_cnt_q - CNT_ONE;
      end else if (bus.flow_ctrl_in && !grant_any_s) begin
         if (credit_cnt_q == CNT_MAX) begin
            err_credit_s = 1'b1;
         end else begin
            credit_cnt_d = credit_cnt_q + CNT_ONE;
         end
      end else begin
         credit_cnt_d = credit_cnt_q;
      end
      error_d = error_q | err_proto_s | err_credit_s;
   end

   // State, owner, pointer, credits, sticky error and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         rr_ptr_q     <= {{(num_ports-1){1'b0}}, 1'b1};
         credit_cnt_q <= CNT_MAX;
         error_q      <= 1'b0;
         xbr_q        <= '0;
         valid_q      <= 1'b0;
         head_q       <= 1'b0;
         tail_q       <= 1'b0;
         full_q       <= (buffer_size == 0);
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         credit_cnt_q <= credit_cnt_d;
         error_q      <= error_d;
         xbr_q        <= gnt_s;
         valid_q      <= grant_any_s;
         head_q       <= |(gnt_s & bus.req_head_ip);
         tail_q       <= |(gnt_s & bus.req_tail_ip);
         full_q       <= (credit_cnt_d == '0);
      end
   end

   assign bus.gnt_ip         = gnt_s;
   assign bus.xbr_ctrl_ip    = xbr_q;
   assign bus.flit_valid_out = valid_q;
   assign bus.flit_head_out  = head_q;
   assign bus.flit_tail_out  = tail_q;
   assign bus.full           = full_q;
   assign bus.error          = error_q;

endmodule

// File: tb/tb_whr_op_sched.sv
// Directed self-checking bench for whr_op_sched: one default instance
// (8 credits) and one shallow instance (2 credits) share clock and reset.
module tb_whr_op_sched;
   import whr_op_sched_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   whr_op_sched_if #(.NUM_PORTS(5)) bus_a ();
   whr_op_sched_if #(.NUM_PORTS(5)) bus_b ();

   whr_op_sched #(.num_ports(5), .buffer_size(8), .credit_bypass(1)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   whr_op_sched #(.num_ports(5), .buffer_size(2), .credit_bypass(1)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive instance A then move to the sampling (falling) edge
   task automatic cyc_a(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t, input logic f);
      bus_a.req_ip = r; bus_a.req_head_ip = h; bus_a.req_tail_ip = t; bus_a.flow_ctrl_in = f;
      @(negedge clk);
   endtask

   task automatic cyc_b(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t, input logic f);
      bus_b.req_ip = r; bus_b.req_head_ip = h; bus_b.req_tail_ip = t; bus_b.flow_ctrl_in = f;
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus_a.req_ip = '0; bus_a.req_head_ip = '0; bus_a.req_tail_ip = '0; bus_a.flow_ctrl_in = 1'b0;
      bus_b.req_ip = '0; bus_b.req_head_ip = '0; bus_b.req_tail_ip = '0; bus_b.flow_ctrl_in = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      chk("rst_gnt",   bus_a.gnt_ip, 32'h0);
      chk("rst_xbr",   bus_a.xbr_ctrl_ip, 32'h0);
      chk("rst_valid", bus_a.flit_valid_out, 32'h0);
      chk("rst_full",  bus_a.full, 32'h0);
      chk("rst_err",   bus_a.error, 32'h0);
      chk("rst_fullb", bus_b.full, 32'h0);
      chk("rst_cred",  u_dut_a.credit_cnt_q, 32'd8);
      tick();

      // ip1 and ip3 each send 3-flit packets, heads in cycle 0
      cyc_a(5'b01010, 5'b01010, 5'b00000, 1'b0);
      chk("t1_c0_gnt", bus_a.gnt_ip, 32'h02);
      tick();
      cyc_a(5'b01010, 5'b01000, 5'b00000, 1'b0);
      chk("t1_c1_gnt", bus_a.gnt_ip, 32'h02);
      chk("t1_c1_xbr", bus_a.xbr_ctrl_ip, 32'h02);
      chk("t1_c1_vld", bus_a.flit_valid_out, 32'h1);
      chk("t1_c1_hd",  bus_a.flit_head_out, 32'h1);
      chk("t1_c1_tl",  bus_a.flit_tail_out, 32'h0);
      tick();
      cyc_a(5'b01010, 5'b01000, 5'b00010, 1'b0);
      chk("t1_c2_gnt", bus_a.gnt_ip, 32'h02);
      chk("t1_c2_hd",  bus_a.flit_head_out, 32'h0);
      tick();
      cyc_a(5'b01000, 5'b01000, 5'b00000, 1'b0);
      chk("t1_c3_gnt", bus_a.gnt_ip, 32'h08);
      chk("t1_c3_xbr", bus_a.xbr_ctrl_ip, 32'h02);
      chk("t1_c3_tl",  bus_a.flit_tail_out, 32'h1);
      tick();
      cyc_a(5'b01000, 5'b00000, 5'b00000, 1'b0);
      chk("t1_c4_gnt", bus_a.gnt_ip, 32'h08);
      chk("t1_c4_xbr", bus_a.xbr_ctrl_ip, 32'h08);
      tick();
      cyc_a(5'b01000, 5'b00000, 5'b01000, 1'b0);
      chk("t1_c5_gnt", bus_a.gnt_ip, 32'h08);
      tick();
      cyc_a(5'b00000, 5'b00000, 5'b00000, 1'b0);
      chk("t1_c6_gnt",  bus_a.gnt_ip, 32'h0);
      chk("t1_c6_tl",   bus_a.flit_tail_out, 32'h1);
      chk("t1_c6_cred", u_dut_a.credit_cnt_q, 32'd2);
      chk("t1_c6_err",  bus_a.error, 32'h0);
      do_reset();

      // non-head request in IDLE: ignored and flagged
      cyc_a(5'b00010, 5'b00000, 5'b00000, 1'b0);
      chk("nh_gnt", bus_a.gnt_ip, 32'h0);
      tick();
      cyc_a(5'b00000, 5'b00000, 5'b00000, 1'b0);
      chk("nh_err", bus_a.error, 32'h1);
      do_reset();
      @(negedge clk);
      chk("nh_err_clr", bus_a.error, 32'h0);
      tick();

      // ip2 locked, ip0 head waiting
      cyc_a(5'b00100, 5'b00100, 5'b00000, 1'b0);
      chk("t2_c0_gnt", bus_a.gnt_ip, 32'h04);
      tick();
      cyc_a(5'b00101, 5'b00001, 5'b00000, 1'b0);
      chk("t2_c1_gnt", bus_a.gnt_ip, 32'h04);
      tick();
      cyc_a(5'b00101, 5'b00001, 5'b00000, 1'b0);
      chk("t2_c2_gnt", bus_a.gnt_ip, 32'h04);
      tick();
      cyc_a(5'b00101, 5'b00001, 5'b00100, 1'b0);
      chk("t2_c3_gnt", bus_a.gnt_ip, 32'h04);
      tick();
      cyc_a(5'b00001, 5'b00001, 5'b00001, 1'b0);
      chk("t2_c4_gnt", bus_a.gnt_ip, 32'h01);
      chk("t2_c4_err", bus_a.error, 32'h0);
      tick();
      cyc_a(5'b00000, 5'b00000, 5'b00000, 1'b0);
      chk("t2_c5_xbr", bus_a.xbr_ctrl_ip, 32'h01);
      do_reset();

      // shallow buffer: two grants, stall, bypassed credit
      cyc_b(5'b00001, 5'b00001, 5'b00000, 1'b0);
      chk("t3_c0_gnt", bus_b.gnt_ip, 32'h01);
      tick();
      cyc_b(5'b00001, 5'b00000, 5'b00000, 1'b0);
      chk("t3_c1_gnt",  bus_b.gnt_ip, 32'h01);
      chk("t3_c1_full", bus_b.full, 32'h0);
      tick();
      cyc_b(5'b00001, 5'b00000, 5'b00000, 1'b0);
      chk("t3_c2_gnt",  bus_b.gnt_ip, 32'h0);
      chk("t3_c2_full", bus_b.full, 32'h1);
      tick();
      cyc_b(5'b00001, 5'b00000, 5'b00000, 1'b0);
      chk("t3_c3_gnt",  bus_b.gnt_ip, 32'h0);
      tick();
      cyc_b(5'b00001, 5'b00000, 5'b00000, 1'b1);
      chk("t3_c4_gnt",  bus_b.gnt_ip, 32'h01);
      tick();
      cyc_b(5'b00001, 5'b00000, 5'b00001, 1'b0);
      chk("t3_c5_gnt",  bus_b.gnt_ip, 32'h0);
      chk("t3_c5_full", bus_b.full, 32'h1);
      chk("t3_c5_vld",  bus_b.flit_valid_out, 32'h1);
      tick();
      cyc_b(5'b00001, 5'b00000, 5'b00001, 1'b1);
      chk("t3_c6_gnt",  bus_b.gnt_ip, 32'h01);
      tick();
      cyc_b(5'b00000, 5'b00000, 5'b00000, 1'b1);
      chk("t3_c7_tl",   bus_b.flit_tail_out, 32'h1);
      chk("t3_c7_full", bus_b.full, 32'h1);
      tick();
      cyc_b(5'b00000, 5'b00000, 5'b00000, 1'b0);
      chk("t3_c8_full", bus_b.full, 32'h0);
      do_reset();

      // grant and credit return together for 10 cycles
      for (int i = 0; i < 10; i++) begin
         cyc_a(5'b00001, (i == 0) ? 5'b00001 : 5'b00000, (i == 9) ? 5'b00001 : 5'b00000, 1'b1);
         chk("t4_gnt",  bus_a.gnt_ip, 32'h01);
         chk("t4_cred", u_dut_a.credit_cnt_q, 32'd8);
         chk("t4_full", bus_a.full, 32'h0);
         chk("t4_err",  bus_a.error, 32'h0);
         tick();
      end

      // credit overflow at full count
      cyc_a(5'b00000, 5'b00000, 5'b00000, 1'b1);
      chk("t5_err0", bus_a.error, 32'h0);
      tick();
      cyc_a(5'b00000, 5'b00000, 5'b00000, 1'b0);
      chk("t5_err1", bus_a.error, 32'h1);
      chk("t5_cred", u_dut_a.credit_cnt_q, 32'd8);
      tick();
      tick();
      tick();
      @(negedge clk);
      chk("t5_hold", bus_a.error, 32'h1);
      do_reset();
      @(negedge clk);
      chk("t5_clr", bus_a.error, 32'h0);
      tick();

      // owner re-sends a head while locked
      cyc_a(5'b00010, 5'b00010, 5'b00000, 1'b0);
      tick();
      cyc_a(5'b00010, 5'b00010, 5'b00000, 1'b0);
      chk("oh_gnt", bus_a.gnt_ip, 32'h02);
      tick();
      cyc_a(5'b00000, 5'b00000, 5'b00000, 1'b0);
      chk("oh_err", bus_a.error, 32'h1);
      do_reset();

      // reset mid-packet on ip4
      cyc_a(5'b10000, 5'b10000, 5'b00000, 1'b0);
      chk("t6_c0_gnt", bus_a.gnt_ip, 32'h10);
      tick();
      cyc_a(5'b10000, 5'b00000, 5'b00000, 1'b0);
      chk("t6_c1_gnt", bus_a.gnt_ip, 32'h10);
      tick();
      do_reset();
      @(negedge clk);
      chk("t6_state", u_dut_a.state_q, 32'(ST_IDLE));
      chk("t6_cred",  u_dut_a.credit_cnt_q, 32'd8);
      chk("t6_xbr",   bus_a.xbr_ctrl_ip, 32'h0);
      chk("t6_vld",   bus_a.flit_valid_out, 32'h0);
      tick();
      cyc_a(5'b10001, 5'b10001, 5'b10001, 1'b0);
      chk("t6_rr", bus_a.gnt_ip, 32'h01);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
